plot_sink: RTL

- Receiving end of the pixel-plot interface used by the drawing datapaths (wall, snake, apple painters), which emit x/y/colour/plot.
- Accepts plot requests into a small FIFO and drops off-screen coordinates.
- Converts each request to a linear 160x120 frame-buffer address and drives a single write port to the frame RAM, with arbitration backpressure.
- Also provides a full-screen clear sweep used on game restart.

---
 rtl/plot_sink_if.sv | 29 ++
 rtl/plot_sink.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/plot_sink_if.sv
// plot_sink_if: plot request handshake, clear control and frame-RAM write port.
// Latency: none, wiring only.
// Backpressure: plot_ready (sink to source) and mem_grant (RAM to sink).
interface plot_sink_if;
    logic        plot_valid;
    logic        plot_ready;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        clear_req;
    logic        clear_busy;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_grant;
    logic [7:0]  drop_count;

    // Plot source / RAM arbiter side
    modport master (
        output plot_valid, x, y, colour, clear_req, mem_grant,
        input  plot_ready, clear_busy, mem_we, mem_addr, mem_data, drop_count
    );

    // plot_sink side
    modport slave (
        input  plot_valid, x, y, colour, clear_req, mem_grant,
        output plot_ready, clear_busy, mem_we, mem_addr, mem_data, drop_count
    );
endinterface

// File: rtl/plot_sink.sv
// plot_sink: queues 160x120 pixel plots, drops off-screen ones, writes frame RAM; full-screen clear sweep.
// Latency: accepted plot shows on mem_we two cycles later (FIFO push, then output register load).
// Backpressure: plot_ready low when FIFO full or clear busy; output register holds while !mem_grant.
// Optional feature macro: PLOT_SINK_DROP_COUNT_EN enables the saturating off-screen drop counter.
module plot_sink #(
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    plot_sink_if.slave bus
);
    localparam int             PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [14:0]    LAST_ADDR = 15'd19199;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  colour;
    } pix_t;

    typedef enum logic [1:0] {
        RUN,
        WAIT_DRAIN,
        CLEAR
    } state_t;

    state_t         state_q, state_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    pix_t           fifo_mem_q [FIFO_DEPTH];
    pix_t           fifo_mem_d [FIFO_DEPTH];
    logic           out_vld_q, out_vld_d;
    pix_t           out_q, out_d;

    logic fifo_empty;
    logic fifo_full;
    logic on_screen;
    logic accept;
    logic push;
    logic pop;
    logic load_en;
    pix_t push_ent;
    pix_t head_ent;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign bus.plot_ready = !reset && !fifo_full && (state_q == RUN);
    assign bus.clear_busy = (state_q != RUN);

    assign on_screen = (bus.x < 8'd160) && (bus.y < 7'd120);
    assign accept    = bus.plot_valid && bus.plot_ready;
    assign push      = accept && on_screen;

    // y*160 + x as two shifts and an add; max 19199 fits in 15 bits.
    assign push_ent.addr   = {1'b0, bus.y, 7'b0} + {3'b0, bus.y, 5'b0} + {7'b0, bus.x};
    assign push_ent.colour = bus.colour;
    assign head_ent        = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    assign bus.mem_we   = out_vld_q;
    assign bus.mem_addr = out_q.addr;
    assign bus.mem_data = out_q.colour;

    // FIFO next state: write at tail on push, advance head on pop.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = push_ent;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Control FSM and output register: drain plots, then sweep the clear address through the same register.
    always_comb begin
        state_d   = state_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        pop       = 1'b0;
        load_en   = !out_vld_q || bus.mem_grant;
        case (state_q)
            RUN: begin
                if (load_en) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        out_vld_d = 1'b1;
                        out_d     = head_ent;
                    end else begin
                        out_vld_d = 1'b0;
                    end
                end
                if (bus.clear_req) begin
                    state_d = WAIT_DRAIN;
                end
            end
            WAIT_DRAIN: begin
                if (fifo_empty && !out_vld_q) begin
                    // Both stages empty: first clear pixel goes straight into the output register.
                    state_d      = CLEAR;
                    out_vld_d    = 1'b1;
                    out_d.addr   = 15'd0;
                    out_d.colour = CLEAR_COLOUR;
                end else if (load_en) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        out_vld_d = 1'b1;
                        out_d     = head_ent;
                    end else begin
                        out_vld_d = 1'b0;
                    end
                end
            end
            CLEAR: begin
                // The output address doubles as the sweep counter; it only moves on a committed write.
                if (out_vld_q && bus.mem_grant) begin
                    if (out_q.addr == LAST_ADDR) begin
                        out_vld_d = 1'b0;
                        state_d   = RUN;
                    end else begin
                        out_d.addr   = out_q.addr + 15'd1;
                        out_d.colour = CLEAR_COLOUR;
                    end
                end
            end
            default: begin
                state_d   = RUN;
                out_vld_d = 1'b0;
            end
        endcase
    end

    // Control and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

`ifdef PLOT_SINK_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Count accepted off-screen plots, saturating at 255.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !on_screen && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_count = drop_cnt_q;
`else
    assign bus.drop_count = 8'd0;
`endif

endmodule
